jelly3_multiword_adder: RTL and testbench



---
 rtl/jelly3_multiword_adder_pkg.sv | 19 +
 rtl/jelly3_carry_chain.sv | 47 ++++
 rtl/jelly3_multiword_adder.sv | 130 +++++++++++++
 tb/tb_jelly3_multiword_adder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jelly3_multiword_adder_pkg.sv
// Shared types and helpers for the multi-word adder: FSM state encoding
// and the width of the chunk index.
package jelly3_multiword_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that selects one of n chunks; never narrower than 1 bit
    // so that a single-chunk configuration still has a legal index register.
    function automatic int idx_bits(input int n);
        int b;
        b = $clog2(n);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/jelly3_carry_chain.sv
// Narrow carry chain in the style of a fabric carry primitive: each bit
// either propagates the incoming carry (sin=1) or generates din (sin=0).
// Every per-bit carry is exposed so callers can derive signed overflow.
module jelly3_carry_chain #(
    parameter int    DATA_BITS  = 8,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                 cin,
    input  logic [DATA_BITS-1:0] sin,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [DATA_BITS-1:0] cout
);

    // Returns {cout, dout} for one pass through the chain.
    function automatic logic [2*DATA_BITS-1:0] chain_calc(
        input logic                 c_in,
        input logic [DATA_BITS-1:0] s,
        input logic [DATA_BITS-1:0] d
    );
        logic                 c;
        logic [DATA_BITS-1:0] o;
        logic [DATA_BITS-1:0] co;
        c  = c_in;
        o  = '0;
        co = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            o[i]  = s[i] ^ c;
            c     = s[i] ? c : d[i];
            co[i] = c;
        end
        return {co, o};
    endfunction

    generate
        if (DEVICE == "RTL" || SIMULATION == "true" || DEBUG == "true") begin : g_rtl
            // Behavioural chain for simulation and generic targets.
            assign {cout, dout} = chain_calc(cin, sin, din);
        end else begin : g_device
            // Vendor targets: the mux/xor structure maps onto the device carry logic.
            assign {cout, dout} = chain_calc(cin, sin, din);
        end
    endgenerate

endmodule

// File: rtl/jelly3_multiword_adder.sv
// Wide adder/subtractor that walks one DATA_BITS carry chain across WORDS
// chunks, least-significant chunk first, holding the carry in a register.
//
// Handshakes: a request transfers on a clk edge where s_valid && s_ready && cke;
// a result transfers on a clk edge where m_valid && m_ready && cke. Once
// asserted, m_valid and the result stay stable until the transfer; s_valid
// is ignored while s_ready is low.
module jelly3_multiword_adder
    import jelly3_multiword_adder_pkg::*;
#(
    parameter int    DATA_BITS  = 8,
    parameter int    WORDS      = 4,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                       reset,
    input  logic                       clk,
    input  logic                       cke,

    input  logic [WORDS*DATA_BITS-1:0] s_a,
    input  logic [WORDS*DATA_BITS-1:0] s_b,
    input  logic                       s_sub,
    input  logic                       s_valid,
    output logic                       s_ready,

    output logic [WORDS*DATA_BITS-1:0] m_sum,
    output logic                       m_carry,
    output logic                       m_overflow,
    output logic                       m_valid,
    input  logic                       m_ready
);

    localparam int W     = WORDS * DATA_BITS;
    localparam int IDX_W = idx_bits(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // FSM state is kept as a named typed register so checkers can bind to it.
    state_t                state;
    logic [W-1:0]          a_reg;
    logic [W-1:0]          b_reg;
    logic                  sub_reg;
    logic [IDX_W-1:0]      index;
    logic                  carry;

    logic [DATA_BITS-1:0]  chunk_a;
    logic [DATA_BITS-1:0]  chunk_b;
    logic [DATA_BITS-1:0]  chain_dout;
    logic [DATA_BITS-1:0]  chain_cout;
    int                    chunk_lsb;

    // Select the current chunk; subtraction inverts B and seeds carry with 1.
    always_comb begin
        chunk_lsb = int'(index) * DATA_BITS;
        chunk_a   = a_reg[chunk_lsb +: DATA_BITS];
        chunk_b   = b_reg[chunk_lsb +: DATA_BITS] ^ {DATA_BITS{sub_reg}};
    end

    jelly3_carry_chain #(
        .DATA_BITS  (DATA_BITS),
        .DEVICE     (DEVICE),
        .SIMULATION (SIMULATION),
        .DEBUG      (DEBUG)
    ) u_carry_chain (
        .cin  (carry),
        .sin  (chunk_a ^ chunk_b),
        .din  (chunk_a),
        .dout (chain_dout),
        .cout (chain_cout)
    );

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_sum      <= '0;
            m_carry    <= 1'b0;
            m_overflow <= 1'b0;
            index      <= '0;
            carry      <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            sub_reg    <= 1'b0;
        end else if (cke) begin
            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        a_reg   <= s_a;
                        b_reg   <= s_b;
                        sub_reg <= s_sub;
                        index   <= '0;
                        carry   <= s_sub;
                        s_ready <= 1'b0;
                        state   <= RUN;
                    end
                end

                RUN: begin
                    m_sum[chunk_lsb +: DATA_BITS] <= chain_dout;
                    carry <= chain_cout[DATA_BITS-1];
                    if (index == LAST_IDX) begin
                        m_carry    <= chain_cout[DATA_BITS-1];
                        m_overflow <= chain_cout[DATA_BITS-1] ^ chain_cout[DATA_BITS-2];
                        m_valid    <= 1'b1;
                        state      <= DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end

                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jelly3_multiword_adder.sv
// Directed bench for the multi-word adder with DATA_BITS=8, WORDS=4.
module tb_jelly3_multiword_adder;

    localparam int W = 32;

    logic         reset;
    logic         clk;
    logic         cke;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;
    logic         s_sub;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] m_sum;
    logic         m_carry;
    logic         m_overflow;
    logic         m_valid;
    logic         m_ready;

    int n_cmp = 0;
    int n_err = 0;

    jelly3_multiword_adder #(
        .DATA_BITS  (8),
        .WORDS      (4),
        .DEVICE     ("RTL"),
        .SIMULATION ("false"),
        .DEBUG      ("false")
    ) dut (
        .reset      (reset),
        .clk        (clk),
        .cke        (cke),
        .s_a        (s_a),
        .s_b        (s_b),
        .s_sub      (s_sub),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_sum      (m_sum),
        .m_carry    (m_carry),
        .m_overflow (m_overflow),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with m_ready held high; checks latency and result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input string name);
        int cyc;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_ready_before: got %b want 1", name, s_ready);
        end
        s_a = a; s_b = b; s_sub = sub; s_valid = 1'b1; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        s_a = $urandom; s_b = $urandom; s_sub = 1'($urandom_range(0, 1));
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != 4) begin
            n_err++;
            $display("FAIL %s_latency: got %0d want 4", name, cyc);
        end
        n_cmp++;
        if (m_sum !== es) begin
            n_err++;
            $display("FAIL %s_sum: got %h want %h", name, m_sum, es);
        end
        n_cmp++;
        if (m_carry !== ec) begin
            n_err++;
            $display("FAIL %s_carry: got %b want %b", name, m_carry, ec);
        end
        n_cmp++;
        if (m_overflow !== eo) begin
            n_err++;
            $display("FAIL %s_overflow: got %b want %b", name, m_overflow, eo);
        end
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s_ready_done: got %b want 0", name, s_ready);
        end
        tick();
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_consume: got valid=%b ready=%b want valid=0 ready=1",
                     name, m_valid, s_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cke = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        s_a = '0; s_b = '0; s_sub = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_sum !== 32'h0 ||
            m_carry !== 1'b0 || m_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got ready=%b valid=%b sum=%h c=%b ov=%b want 1 0 0 0 0",
                     s_ready, m_valid, m_sum, m_carry, m_overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add();
        run_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "add_ff_1");
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, "add_wrap");
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "add_ovf");
    endtask

    task automatic test_sub();
        run_op(32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0, "sub_5_3");
        run_op(32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf");
    endtask

    task automatic test_backpressure();
        int cyc;
        m_ready = 1'b0;
        s_a = 32'h11111111; s_b = 32'h22222222; s_sub = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (cyc != 4) begin
            n_err++;
            $display("FAIL bp_latency: got %0d want 4", cyc);
        end
        for (int i = 0; i < 10; i++) begin
            // A request offered while busy must not be taken.
            s_a = $urandom; s_b = $urandom; s_sub = 1'($urandom_range(0, 1)); s_valid = 1'b1;
            tick();
            n_cmp++;
            if (m_valid !== 1'b1 || m_sum !== 32'h33333333 || m_carry !== 1'b0 ||
                m_overflow !== 1'b0 || s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got valid=%b sum=%h c=%b ov=%b ready=%b want 1 33333333 0 0 0",
                         i, m_valid, m_sum, m_carry, m_overflow, s_ready);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        m_ready = 1'b1;
        s_a = 32'h01010101; s_b = 32'h02020202; s_sub = 1'b0; s_valid = 1'b1;
        tick();
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_cmp++;
        if (m_sum !== 32'h03030303) begin
            n_err++;
            $display("FAIL b2b_first_sum: got %h want 03030303", m_sum);
        end
        s_a = 32'h10000000; s_b = 32'h20000000;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (m_valid !== 1'b1 && cyc < 20);
        s_valid = 1'b0;
        n_cmp++;
        if (cyc != 6) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d want 6", cyc);
        end
        n_cmp++;
        if (m_sum !== 32'h30000000) begin
            n_err++;
            $display("FAIL b2b_second_sum: got %h want 30000000", m_sum);
        end
        tick();
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drain: got valid=%b ready=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_cke_stall();
        int cyc;
        m_ready = 1'b1;
        s_a = 32'h12345678; s_b = 32'h0FEDCBA9; s_sub = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 20) begin
            cke = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
            tick();
            cyc++;
        end
        cke = 1'b1;
        n_cmp++;
        if (cyc != 7) begin
            n_err++;
            $display("FAIL cke_latency: got %0d want 7", cyc);
        end
        n_cmp++;
        if (m_sum !== 32'h22222221 || m_carry !== 1'b0 || m_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL cke_result: got sum=%h c=%b ov=%b want 22222221 0 0",
                     m_sum, m_carry, m_overflow);
        end
        tick();
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cke_drain: got valid=%b ready=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_reset_abort();
        m_ready = 1'b1;
        s_a = 32'hFFFFFFFF; s_b = 32'hFFFFFFFF; s_sub = 1'b0; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        // Now in RUN at index 2; reset asynchronously between edges.
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_sum !== 32'h0) begin
            n_err++;
            $display("FAIL abort_async: got valid=%b ready=%b sum=%h want 0 1 00000000",
                     m_valid, s_ready, m_sum);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
                n_err++;
                $display("FAIL abort_quiet_%0d: got valid=%b ready=%b want 0 1", i, m_valid, s_ready);
            end
        end
        run_op(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_back_to_back();
        test_cke_stall();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
